// File: rtl/fifo1_pkg.sv
// Shared defaults and pointer-width helper for the fifo_1 FIFO.
package fifo1_pkg;

   localparam int unsigned FIFO1_DATA_WIDTH = 8;
   localparam int unsigned FIFO1_DEPTH      = 8;

   // Pointers carry one extra wrap bit above the array index.
   function automatic int unsigned fifo1_ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo1_mem.sv
// Storage array for fifo_1: synchronous write, registered read port.
module fifo1_mem
   import fifo1_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO1_DATA_WIDTH,
   parameter int unsigned DEPTH      = FIFO1_DEPTH,
   parameter int unsigned AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   // Array contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fifo_1.sv
// Single-clock byte FIFO with wrap-bit pointers and full/empty flags.
// Optional occupancy output `count` is enabled by defining FIFO1_COUNT_EN.
module fifo_1
   import fifo1_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO1_DATA_WIDTH,
   parameter int unsigned DEPTH      = FIFO1_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     w_en,
   input  logic                     r_en,
   input  logic [DATA_WIDTH-1:0]    data_in,
   output logic [DATA_WIDTH-1:0]    data_out,
`ifdef FIFO1_COUNT_EN
   output logic [$clog2(DEPTH):0]   count,
`endif
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = fifo1_ptr_width(DEPTH);
   localparam int unsigned AW = PW - 1;

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          wr_ok;
   logic          rd_ok;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign wr_ok = w_en && !full;
   assign rd_ok = r_en && !empty;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_ok) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (rd_ok) begin
         rptr_d = rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

`ifdef FIFO1_COUNT_EN
   assign count = wptr_q - rptr_q;
`endif

   fifo1_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok),
      .waddr (wptr_q[AW-1:0]),
      .wdata (data_in),
      .re    (rd_ok),
      .raddr (rptr_q[AW-1:0]),
      .rdata (data_out)
   );

endmodule

// File: tb/tb_fifo_1.sv
// Directed self-checking bench for fifo_1 (DEPTH=8, DATA_WIDTH=8).
module tb_fifo_1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       w_en;
   logic       r_en;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
`ifdef FIFO1_COUNT_EN
   logic [3:0] count;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;

   fifo_1 #(
      .DATA_WIDTH (8),
      .DEPTH      (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_en     (w_en),
      .r_en     (r_en),
      .data_in  (data_in),
      .data_out (data_out),
`ifdef FIFO1_COUNT_EN
      .count    (count),
`endif
      .full     (full),
      .empty    (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] q[$];
   logic [7:0] last;

   initial begin
      rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;

      // Reset with random activity on the inputs
      for (int i = 0; i < 4; i++) begin
         w_en    = 1'($urandom);
         r_en    = 1'($urandom);
         data_in = 8'($urandom);
         step();
      end
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_dout", data_out, 8'h00);
`ifdef FIFO1_COUNT_EN
      chk("rst_count", count, 0);
`endif
      w_en = 1'b0; r_en = 1'b0;
      rst_n = 1'b1;
      step(); step();
      chk("idle_empty", empty, 1);
      chk("idle_dout", data_out, 8'h00);

      // Fill: 10 writes, last two dropped
      for (int i = 0; i < 10; i++) begin
         w_en = 1'b1; data_in = 8'h11 + 8'(i);
         step();
         chk($sformatf("fill_full_%0d", i), full, (i >= 7) ? 1 : 0);
         chk($sformatf("fill_empty_%0d", i), empty, 0);
      end
      w_en = 1'b0;
`ifdef FIFO1_COUNT_EN
      chk("fill_count", count, 8);
`endif

      // Drain: 10 reads, last two dropped
      for (int i = 0; i < 10; i++) begin
         r_en = 1'b1;
         step();
         chk($sformatf("drain_dout_%0d", i), data_out, (i < 8) ? (8'h11 + 8'(i)) : 8'h18);
         chk($sformatf("drain_empty_%0d", i), empty, (i >= 7) ? 1 : 0);
         chk($sformatf("drain_full_%0d", i), full, 0);
      end
      r_en = 1'b0;

      // Simultaneous write+read at empty: write wins, read dropped
      w_en = 1'b1; r_en = 1'b1; data_in = 8'h5C;
      step();
      chk("bnd_empty_dout", data_out, 8'h18);
      chk("bnd_empty_flag", empty, 0);
      w_en = 1'b0;
      step();
      chk("bnd_empty_rd", data_out, 8'h5C);
      chk("bnd_empty_after", empty, 1);
      r_en = 1'b0;

      // Simultaneous write+read at full: read wins, write dropped
      for (int i = 0; i < 8; i++) begin
         w_en = 1'b1; data_in = 8'h20 + 8'(i);
         step();
      end
      chk("bnd_full_pre", full, 1);
      w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE;
      step();
      chk("bnd_full_dout", data_out, 8'h20);
      chk("bnd_full_flag", full, 0);
      w_en = 1'b0;
      for (int i = 1; i < 8; i++) begin
         step();
         chk($sformatf("bnd_full_rd_%0d", i), data_out, 8'h20 + 8'(i));
      end
      chk("bnd_full_empty", empty, 1);
      r_en = 1'b0;
      step();
      chk("bnd_full_hold", data_out, 8'h27);

      // Staggered streaming: 24 writes, reads start 5 cycles later
      q.delete();
      for (int c = 0; c < 29; c++) begin
         w_en = (c < 24);
         r_en = (c >= 5);
         data_in = 8'h40 + 8'(c);
         if (r_en && q.size() > 0) last = q.pop_front();
         if (w_en && q.size() < 8) q.push_back(data_in);
         step();
         if (c >= 5) chk($sformatf("stream_%0d", c), data_out, last);
      end
      w_en = 1'b0; r_en = 1'b0;
      chk("stream_empty", empty, 1);
      chk("stream_last", data_out, 8'h57);

      // Mid-operation reset with 5 entries stored
      for (int i = 0; i < 5; i++) begin
         w_en = 1'b1; data_in = 8'h60 + 8'(i);
         step();
      end
      w_en = 1'b0;
      chk("mid_pre_empty", empty, 0);
`ifdef FIFO1_COUNT_EN
      chk("mid_pre_count", count, 5);
`endif
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_dout", data_out, 8'h00);
`ifdef FIFO1_COUNT_EN
      chk("mid_rst_count", count, 0);
`endif
      step();
      rst_n = 1'b1;
      w_en = 1'b1; data_in = 8'hA5;
      step();
      w_en = 1'b0; r_en = 1'b1;
      step();
      r_en = 1'b0;
      chk("mid_a5_dout", data_out, 8'hA5);
      chk("mid_a5_empty", empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
